dmem_responder: RTL and testbench

- Data-memory responder on the far end of the CPU load/store interface.
- Accepts one request at a time. Each request carries the store enable, RWType (funct3 encoding), address and write data.
- After a programmable wait time it performs the byte/half/word access on an internal word array. Loads return the data sign- or zero-extended and aligned to bit 0.
- Misaligned, out-of-range and illegal-type requests are flagged and have no side effects. The block stands in for a multi-cycle data memory when the datapath is made stall-aware.

---
 rtl/dmem_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the far end of the CPU load/store interface.
//   It accepts one request at a time, waits WAIT_CYCLES cycles, then runs a
//   byte/half/word access on an internal little-endian word array. A load
//   returns its data aligned to bit 0, sign- or zero-extended. A misaligned,
//   out-of-range or illegal-type request is flagged and changes nothing.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset (does not clear the array)
//   req_valid   request present
//   req_ready   block can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_type    RWType: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data (low byte/half used for B/H)
//   resp_valid  one-cycle response pulse
//   resp_rdata  load result, 0 for stores, for errors and outside RESP
//   resp_err    request rejected, valid with resp_valid

module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);
    // Counter start value. It is never loaded when WAIT_CYCLES is 0.
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [2:0]  type_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] mem_r [DEPTH];

    logic        sel_we_s;
    logic [2:0]  sel_type_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_word_s;
    logic        sel_err_s;
    logic [31:0] sel_rdata_s;

    // Returns 1 when the request would be rejected.
    function automatic logic req_error(input logic        we,
                                       input logic [2:0]  rw_type,
                                       input logic [31:0] addr);
        logic bad;
        case (rw_type)
            3'b000:  bad = 1'b0;
            3'b100:  bad = we;
            3'b001:  bad = addr[0];
            3'b101:  bad = we | addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    // Picks the addressed byte or half out of a word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0]  rw_type,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (rw_type)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merges store data into the old word and leaves the other lanes as they were.
    function automatic logic [31:0] store_merge(input logic [2:0]  rw_type,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (rw_type)
            3'b000: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            3'b010:  r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    // Request that the next RESP cycle will answer: the live inputs when the
    // response follows acceptance directly, otherwise the latched copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_we_s   = req_we;
            sel_type_s = req_type;
            sel_addr_s = req_addr;
        end else begin
            sel_we_s   = we_r;
            sel_type_s = type_r;
            sel_addr_s = addr_r;
        end
    end

    assign sel_word_s = mem_r[sel_addr_s[AW+1:2]];

    // Response data is computed on the edge that enters RESP. The array cannot
    // change before RESP ends, so this equals a combinational read during RESP.
    always_comb begin
        sel_err_s = req_error(sel_we_s, sel_type_s, sel_addr_s);
        if (sel_err_s || sel_we_s) begin
            sel_rdata_s = 32'd0;
        end else begin
            sel_rdata_s = load_extract(sel_type_s, sel_addr_s[1:0], sel_word_s);
        end
    end

    // Control FSM, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            type_r     <= 3'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        type_r    <= req_type;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= sel_rdata_s;
                            resp_err   <= sel_err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= sel_rdata_s;
                        resp_err   <= sel_err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Store commit on the edge that ends RESP. A reset on that edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && state_r == ST_RESP && we_r && !resp_err) begin
            mem_r[addr_r[AW+1:2]] <= store_merge(type_r, addr_r[1:0],
                                                 mem_r[addr_r[AW+1:2]], wdata_r);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int NB    = 4 * DEPTH;   // bytes per array

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0
    logic [1:0]       rst;
    logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [1:0][2:0]  req_type;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    int               wait_of [2] = '{2, 0};

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_type(req_type[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_type(req_type[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    int checks   = 0;
    int failures = 0;

    // Reference model: a flat byte array per instance.
    logic [7:0] mdl [2][NB];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  rw_type;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model of one access, written from the access rules: size, alignment, range.
    task automatic model_op(input int d, input logic we, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
        int     size;
        bit     legal;
        longint v;
        legal = (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd4) || (t == 3'd5);
        size  = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
        err   = !legal || (we && t[2]) || ((a % size) != 0) || (a >= NB);
        rd    = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) mdl[d][a + k] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < size; k++) v += longint'(mdl[d][a + k]) << (8 * k);
                if (!t[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v -= (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endtask

    // One request/response handshake. Starts and ends on a falling edge.
    task automatic do_req(input int d, input logic we, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd, output bit got);
        int n;
        got = 0; err = 1'b0; rd = 32'd0;
        n = 0;
        while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
        chk("ready_before_req", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_type[d] = t;
        req_addr[d] = a; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d] = $urandom_range(0, 1); req_addr[d] = $urandom; req_wdata[d] = $urandom;
        n = 0;
        while (!resp_valid[d] && n < 20) begin
            chk("busy_ready", 32'(req_ready[d]), 32'd0);
            @(negedge clk); n++;
        end
        got = resp_valid[d];
        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(wait_of[d]));
        chk("ready_in_resp", 32'(req_ready[d]), 32'd0);
        err = resp_err[d]; rd = resp_rdata[d];
        @(negedge clk);
        chk("pulse_end", 32'(resp_valid[d]), 32'd0);
        chk("idle_rdata", resp_rdata[d], 32'd0);
        chk("idle_err", 32'(resp_err[d]), 32'd0);
        chk("ready_after", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic run_check(input int d, input string name, input logic we,
                             input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_err,
                             input logic [31:0] exp_rd);
        logic err; logic [31:0] rd; bit got;
        do_req(d, we, t, a, wd, err, rd, got);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_rdata"}, rd, exp_rd);
    endtask

    task automatic run_model(input int d, input string name, input logic we,
                             input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
        logic e; logic [31:0] r;
        model_op(d, we, t, a, wd, e, r);
        run_check(d, name, we, t, a, wd, e, r);
    endtask

    task automatic rand_phase(input int d, input int n_ops);
        logic [31:0] a;
        for (int w = 0; w < 16; w++) run_model(d, "rinit", 1'b1, 3'b010, 32'(4 * w), $urandom);
        for (int i = 0; i < n_ops; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(NB) + $urandom_range(0, 7);
                1:       a = $urandom;
                2:       a = 32'(NB - 4) + $urandom_range(0, 3);
                default: a = $urandom_range(0, 63);
            endcase
            run_model(d, "rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
    endtask

    initial begin
        logic e; logic [31:0] r;
        rst = 2'b11; req_valid = 2'b00; req_we = 2'b00; req_type = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end

        // Directed vectors, WAIT_CYCLES=2 instance
        vecs.push_back('{"sw10",   1'b1, 3'b010, 32'h10,   32'h8000_80F0, 1'b0, 32'h0});
        vecs.push_back('{"lb10",   1'b0, 3'b000, 32'h10,   32'h0,         1'b0, 32'hFFFF_FFF0});
        vecs.push_back('{"lbu11",  1'b0, 3'b100, 32'h11,   32'h0,         1'b0, 32'h0000_0080});
        vecs.push_back('{"lh12",   1'b0, 3'b001, 32'h12,   32'h0,         1'b0, 32'hFFFF_8000});
        vecs.push_back('{"lhu10",  1'b0, 3'b101, 32'h10,   32'h0,         1'b0, 32'h0000_80F0});
        vecs.push_back('{"lw10",   1'b0, 3'b010, 32'h10,   32'h0,         1'b0, 32'h8000_80F0});
        vecs.push_back('{"sw20",   1'b1, 3'b010, 32'h20,   32'h1122_3344, 1'b0, 32'h0});
        vecs.push_back('{"sb21",   1'b1, 3'b000, 32'h21,   32'hFFFF_FFAB, 1'b0, 32'h0});
        vecs.push_back('{"sh22",   1'b1, 3'b001, 32'h22,   32'h1234_CDEF, 1'b0, 32'h0});
        vecs.push_back('{"lw20",   1'b0, 3'b010, 32'h20,   32'h0,         1'b0, 32'hCDEF_AB44});
        vecs.push_back('{"lh13",   1'b0, 3'b001, 32'h13,   32'h0,         1'b1, 32'h0});
        vecs.push_back('{"lw22",   1'b0, 3'b010, 32'h22,   32'h0,         1'b1, 32'h0});
        vecs.push_back('{"swtop",  1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 1'b1, 32'h0});
        vecs.push_back('{"t011",   1'b0, 3'b011, 32'h10,   32'h0,         1'b1, 32'h0});
        vecs.push_back('{"st100",  1'b1, 3'b100, 32'h20,   32'h0000_0055, 1'b1, 32'h0});
        vecs.push_back('{"st011",  1'b1, 3'b011, 32'h10,   32'h0,         1'b1, 32'h0});
        vecs.push_back('{"lw10b",  1'b0, 3'b010, 32'h10,   32'h0,         1'b0, 32'h8000_80F0});
        vecs.push_back('{"lw20b",  1'b0, 3'b010, 32'h20,   32'h0,         1'b0, 32'hCDEF_AB44});
        vecs.push_back('{"swffc",  1'b1, 3'b010, 32'hFFC,  32'h0BAD_F00D, 1'b0, 32'h0});
        vecs.push_back('{"lbfff",  1'b0, 3'b000, 32'hFFF,  32'h0,         1'b0, 32'h0000_000B});
        vecs.push_back('{"lhffe",  1'b0, 3'b001, 32'hFFE,  32'h0,         1'b0, 32'h0000_0BAD});
        vecs.push_back('{"sw30",   1'b1, 3'b010, 32'h30,   32'hA5A5_0001, 1'b0, 32'h0});
        vecs.push_back('{"lw30",   1'b0, 3'b010, 32'h30,   32'h0,         1'b0, 32'hA5A5_0001});
        foreach (vecs[i]) begin
            model_op(0, vecs[i].we, vecs[i].rw_type, vecs[i].addr, vecs[i].wdata, e, r);
            run_check(0, vecs[i].name, vecs[i].we, vecs[i].rw_type, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset during WAIT drops the store to 0x30
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_type[0] = 3'b010;
        req_addr[0] = 32'h30; req_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wait_ready", 32'(req_ready[0]), 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("no_resp_after_rst", 32'(resp_valid[0]), 32'd0);
            @(negedge clk);
        end
        chk("ready_after_rst", 32'(req_ready[0]), 32'd1);
        run_check(0, "lw30_kept", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hA5A5_0001);

        rand_phase(0, 150);
        rand_phase(1, 150);

        // Back-to-back loads with req_valid held high on the WAIT_CYCLES=0 instance
        model_op(1, 1'b0, 3'b010, 32'h4, 32'h0, e, r);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_type[1] = 3'b010; req_addr[1] = 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(resp_valid[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("b2b_ready", 32'(req_ready[1]), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("b2b_rdata", resp_rdata[1], (i % 2 == 0) ? r : 32'd0);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
